// File: rtl/led_pkg.sv
// Shared constants, state type and helpers for the LED sequencer.
package led_pkg;

    localparam logic [1:0] ADDR_DATA_LO = 2'd0;
    localparam logic [1:0] ADDR_DATA_HI = 2'd1;
    localparam logic [1:0] ADDR_MODE    = 2'd2;
    localparam logic [1:0] ADDR_PERIOD  = 2'd3;

    localparam logic [1:0] MODE_STATIC = 2'd0;
    localparam logic [1:0] MODE_BLINK  = 2'd1;
    localparam logic [1:0] MODE_ROT_L  = 2'd2;
    localparam logic [1:0] MODE_ROT_R  = 2'd3;

    typedef enum logic [1:0] {
        S_STATIC,
        S_ON,
        S_OFF,
        S_ROT
    } state_t;

    function automatic state_t mode_to_state(input logic [1:0] mode);
        case (mode)
            MODE_BLINK: return S_ON;
            MODE_ROT_L,
            MODE_ROT_R: return S_ROT;
            default:    return S_STATIC;
        endcase
    endfunction

    function automatic logic [23:0] rotate1(input logic [23:0] p, input logic left);
        return left ? {p[22:0], p[23]} : {p[0], p[23:1]};
    endfunction

endpackage

// File: rtl/led_sequencer_if.sv
// IO-bus side of the LED sequencer: decode select, strobes, address and data.
interface led_sequencer_if;
    logic        LEDCtrl;
    logic        ioWrite;
    logic        ioRead;
    logic [1:0]  addr;
    logic [15:0] write_data;
    logic [15:0] read_data;

    modport master (output LEDCtrl, ioWrite, ioRead, addr, write_data, input read_data);
    modport slave  (input LEDCtrl, ioWrite, ioRead, addr, write_data, output read_data);
endinterface

// File: rtl/led_timebase.sv
// Prescaler plus step counter; tick marks each sequencing step.
module led_timebase
    import led_pkg::*;
#(
    parameter int PRESCALE = 100000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] period,
    input  logic        clr_all,
    input  logic        clr_rcnt,
    output logic        strobe,
    output logic        tick
);
    localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

    logic [PW-1:0] pcnt_q, pcnt_d;
    logic [15:0]   rcnt_q, rcnt_d;

    // A clearing write on the same cycle discards the step.
    assign strobe = (pcnt_q == PMAX);
    assign tick   = strobe && (rcnt_q == period) && !clr_all && !clr_rcnt;

    always_comb begin
        pcnt_d = strobe ? '0 : pcnt_q + PW'(1);
        rcnt_d = rcnt_q;
        if (strobe) begin
            rcnt_d = (rcnt_q == period) ? 16'd0 : rcnt_q + 16'd1;
        end
        if (clr_rcnt) begin
            rcnt_d = 16'd0;
        end
        if (clr_all) begin
            pcnt_d = '0;
            rcnt_d = 16'd0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pcnt_q <= '0;
            rcnt_q <= 16'd0;
        end else begin
            pcnt_q <= pcnt_d;
            rcnt_q <= rcnt_d;
        end
    end

endmodule

// File: rtl/led_sequencer.sv
// Memory-mapped 24-bit LED controller: static, blink and rotate sequencing.
module led_sequencer
    import led_pkg::*;
#(
    parameter int          PRESCALE   = 100000,
    parameter logic [15:0] PERIOD_RST = 16'd499
) (
    input  logic                  clock,
    input  logic                  reset,
    led_sequencer_if.slave        bus,
    output logic [23:0]           leds,
    output logic                  tick
);
    state_t      state_q, state_d;
    logic [23:0] pattern_q, pattern_d;
    logic [1:0]  mode_q, mode_d;
    logic [15:0] period_q, period_d;
    logic        wr, clr_all, clr_rcnt, strobe;

    assign wr       = bus.LEDCtrl && bus.ioWrite;
    assign clr_all  = wr && (bus.addr == ADDR_MODE);
    assign clr_rcnt = wr && (bus.addr == ADDR_PERIOD);

    led_timebase #(.PRESCALE(PRESCALE)) u_timebase (
        .clock    (clock),
        .reset    (reset),
        .period   (period_q),
        .clr_all  (clr_all),
        .clr_rcnt (clr_rcnt),
        .strobe   (strobe),
        .tick     (tick)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_STATIC;
            pattern_q <= 24'h0;
            mode_q    <= MODE_STATIC;
            period_q  <= PERIOD_RST;
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            mode_q    <= mode_d;
            period_q  <= period_d;
        end
    end

    // Bus writes are applied after the step logic so they win over a coincident tick.
    always_comb begin
        state_d   = state_q;
        pattern_d = pattern_q;
        mode_d    = mode_q;
        period_d  = period_q;
        case (state_q)
            S_ON:    if (tick) state_d = S_OFF;
            S_OFF:   if (tick) state_d = S_ON;
            S_ROT:   if (tick) pattern_d = rotate1(pattern_q, mode_q == MODE_ROT_L);
            default: ;
        endcase
        if (wr) begin
            case (bus.addr)
                ADDR_DATA_LO: pattern_d = {pattern_q[23:16], bus.write_data};
                ADDR_DATA_HI: pattern_d = {bus.write_data[7:0], pattern_q[15:0]};
                ADDR_MODE: begin
                    mode_d  = bus.write_data[1:0];
                    state_d = mode_to_state(bus.write_data[1:0]);
                end
                default:      period_d = bus.write_data;
            endcase
        end
    end

    assign leds = (state_q == S_OFF) ? 24'h0 : pattern_q;

    always_comb begin
        bus.read_data = 16'h0000;
        if (bus.LEDCtrl && bus.ioRead) begin
            case (bus.addr)
                ADDR_DATA_LO: bus.read_data = pattern_q[15:0];
                ADDR_DATA_HI: bus.read_data = {8'h00, pattern_q[23:16]};
                ADDR_MODE:    bus.read_data = {14'h0, mode_q};
                default:      bus.read_data = period_q;
            endcase
        end
    end

    assert property (@(posedge clock) disable iff (reset) tick |-> strobe);

endmodule

// File: tb/tb_led_sequencer.sv
// Self-checking bench for led_sequencer with a cycle-level behavioural model.
module tb_led_sequencer;
    localparam int P = 4;

    logic        clock;
    logic        reset;
    logic [23:0] leds;
    logic        tick;

    led_sequencer_if bus ();

    led_sequencer #(.PRESCALE(P), .PERIOD_RST(16'd1)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus),
        .leds  (leds),
        .tick  (tick)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Model: pattern/mode/period as written, blink phase, and elapsed-time counters.
    bit          m_valid = 1'b0;
    logic [23:0] m_pat;
    logic [1:0]  m_mode;
    logic [15:0] m_per;
    bit          m_on;
    int          m_t;
    int          m_n;

    logic [23:0] leds_s;
    logic        tick_s;
    logic [15:0] rd_s;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] rot(input logic [23:0] p, input bit left);
        if (left) return ((p << 1) | (p >> 23)) & 24'hFFFFFF;
        return ((p >> 1) | (p << 23)) & 24'hFFFFFF;
    endfunction

    task automatic step();
        bit wr, wmode, wper, wdata, strobe, tk;
        logic [23:0] e_leds;
        logic [15:0] e_rd;
        logic [15:0] wd;
        @(negedge clock);
        leds_s = leds;
        tick_s = tick;
        rd_s   = bus.read_data;
        wd     = bus.write_data;
        wr     = bus.LEDCtrl && bus.ioWrite;
        wmode  = wr && bus.addr == 2'd2;
        wper   = wr && bus.addr == 2'd3;
        wdata  = wr && bus.addr < 2'd2;
        strobe = (m_t == P - 1);
        tk     = strobe && (m_n == int'(m_per)) && !wmode && !wper;
        if (m_valid) begin
            e_leds = (m_mode == 2'd1 && !m_on) ? 24'h0 : m_pat;
            e_rd = 16'h0;
            if (bus.LEDCtrl && bus.ioRead) begin
                case (bus.addr)
                    2'd0: e_rd = m_pat[15:0];
                    2'd1: e_rd = {8'h00, m_pat[23:16]};
                    2'd2: e_rd = {14'h0, m_mode};
                    default: e_rd = m_per;
                endcase
            end
            chk("leds", leds_s, e_leds);
            chk("tick", tick_s, tk);
            chk("read_data", rd_s, e_rd);
        end
        if (reset) begin
            m_valid = 1'b1;
            m_pat = 24'h0; m_mode = 2'd0; m_per = 16'd1; m_on = 1'b1;
            m_t = 0; m_n = 0;
        end else begin
            if (tk) begin
                if (m_mode == 2'd1) m_on = !m_on;
                else if (m_mode >= 2'd2 && !wdata) m_pat = rot(m_pat, m_mode == 2'd2);
            end
            if (wmode || wper) m_n = 0;
            else if (strobe) m_n = (m_n == int'(m_per)) ? 0 : m_n + 1;
            m_t = wmode ? 0 : (m_t + 1) % P;
            if (wr) begin
                case (bus.addr)
                    2'd0: m_pat = {m_pat[23:16], wd};
                    2'd1: m_pat = {wd[7:0], m_pat[15:0]};
                    2'd2: begin m_mode = wd[1:0]; m_on = 1'b1; end
                    default: m_per = wd;
                endcase
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        bus.LEDCtrl = 1'b0; bus.ioWrite = 1'b0; bus.ioRead = 1'b0;
        bus.addr = 2'd0; bus.write_data = 16'h0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [15:0] d);
        bus.LEDCtrl = 1'b1; bus.ioWrite = 1'b1; bus.ioRead = 1'b0;
        bus.addr = a; bus.write_data = d;
        step();
        idle();
    endtask

    task automatic rd(input logic [1:0] a, output logic [15:0] v);
        bus.LEDCtrl = 1'b1; bus.ioWrite = 1'b0; bus.ioRead = 1'b1; bus.addr = a;
        step();
        v = rd_s;
        idle();
    endtask

    task automatic steps_to_tick(input int budget, output int k);
        k = 0;
        do begin
            step();
            k++;
        end while (!tick_s && k < budget);
    endtask

    logic [15:0] v;
    int k;
    logic [23:0] rot_exp [3];

    initial begin
        idle();
        reset = 1'b1;
        step(); step();
        reset = 1'b0;

        // reset in the middle of a left rotation
        wr(2'd0, 16'h0001);
        wr(2'd2, 16'h0002);
        for (int i = 0; i < 3; i++) begin
            steps_to_tick(20, k);
            chk("t1_tick_gap", k, 8);
        end
        step();
        chk("t1_leds_rot3", leds_s, 24'h000008);
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        chk("t1_leds_reset", leds_s, 24'h0);
        rd(2'd2, v); chk("t1_mode_reset", v, 16'h0000);
        rd(2'd3, v); chk("t1_period_reset", v, 16'h0001);

        // static pattern
        wr(2'd0, 16'hBEEF);
        wr(2'd1, 16'h12A5);
        step();
        chk("t2_leds", leds_s, 24'hA5BEEF);
        rd(2'd1, v); chk("t2_rd_hi", v, 16'h00A5);
        repeat (100) step();
        chk("t2_leds_hold", leds_s, 24'hA5BEEF);

        // blink, period 2
        wr(2'd0, 16'hFFFF);
        wr(2'd1, 16'h00FF);
        wr(2'd3, 16'd2);
        wr(2'd2, 16'd1);
        steps_to_tick(50, k);
        chk("t3_first_tick", k, 12);
        step();
        chk("t3_leds_off", leds_s, 24'h000000);
        steps_to_tick(50, k);
        chk("t3_second_tick", k + 1, 12);
        step();
        chk("t3_leds_on", leds_s, 24'hFFFFFF);

        // rotate right, period 0
        rot_exp[0] = 24'hC00000; rot_exp[1] = 24'h600000; rot_exp[2] = 24'h300000;
        wr(2'd3, 16'd0);
        wr(2'd0, 16'h0001);
        wr(2'd1, 16'h0080);
        wr(2'd2, 16'd3);
        for (int i = 0; i < 3; i++) begin
            steps_to_tick(20, k);
            chk("t4_tick_gap", k, (i == 0) ? 4 : 3);
            step();
            chk("t4_leds_rot", leds_s, rot_exp[i]);
        end
        rd(2'd0, v); chk("t4_rd_lo", v, 16'h0000);
        rd(2'd1, v); chk("t4_rd_hi", v, 16'h0030);

        // collisions: data write vs tick, mode write vs tick
        wr(2'd0, 16'h0001);
        wr(2'd1, 16'h0000);
        wr(2'd3, 16'd0);
        wr(2'd2, 16'd2);
        repeat (3) step();
        wr(2'd0, 16'h00F0);
        chk("t5_tick_on_data_write", tick_s, 1'b1);
        step();
        chk("t5_write_wins", leds_s, 24'h0000F0);
        repeat (3) step();
        step();
        chk("t5_rot_after_write", leds_s, 24'h0001E0);
        repeat (2) step();
        wr(2'd2, 16'd2);
        chk("t5_tick_discarded", tick_s, 1'b0);
        steps_to_tick(20, k);
        chk("t5_tick_after_mode", k, 4);
        step();
        chk("t5_leds_after_mode", leds_s, 24'h0003C0);

        // bus gating
        wr(2'd2, 16'd0);
        wr(2'd0, 16'h1234);
        bus.LEDCtrl = 1'b0; bus.ioWrite = 1'b1; bus.addr = 2'd0; bus.write_data = 16'hFFFF;
        step();
        idle();
        rd(2'd0, v); chk("t6_gated_write", v, 16'h1234);
        bus.LEDCtrl = 1'b1; bus.ioRead = 1'b0; bus.addr = 2'd0;
        step();
        chk("t6_rd_no_ioread", rd_s, 16'h0000);
        bus.LEDCtrl = 1'b0; bus.ioRead = 1'b1;
        step();
        chk("t6_rd_no_select", rd_s, 16'h0000);
        idle();
        wr(2'd3, 16'h1234);
        rd(2'd3, v); chk("t6_rd_period", v, 16'h1234);

        // random traffic against the model
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 800; i++) begin
            reset = ($urandom_range(0, 199) == 0);
            bus.LEDCtrl = 1'($urandom_range(0, 1));
            bus.ioWrite = ($urandom_range(0, 3) == 0);
            bus.ioRead = 1'($urandom_range(0, 1));
            bus.addr = 2'($urandom_range(0, 3));
            bus.write_data = 16'($urandom);
            if (bus.addr == 2'd3) bus.write_data = 16'($urandom_range(0, 2));
            step();
        end
        reset = 1'b0;
        idle();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
